// File: rtl/exec_branch_if.sv
// Branch kind encoding shared with decode_branch, plus the exec_branch port bundle.
// The package carries only the decoded branch kind.
// The interface groups the upstream request, the downstream result and the fetch redirect.

package exec_branch_pkg;
   typedef enum logic [2:0] {
      bk_invalid = 3'd0,
      bk_beq     = 3'd1,
      bk_bne     = 3'd2,
      bk_blt     = 3'd3,
      bk_bge     = 3'd4,
      bk_bltu    = 3'd5,
      bk_bgeu    = 3'd6
   } branch_kind_t;
endpackage

interface exec_branch_if #(
   parameter int XLEN = 32
);
   // upstream request from decode_branch
   logic                        in_valid;
   logic                        in_ready;
   exec_branch_pkg::branch_kind_t in_kind;
   logic [XLEN-1:0]             in_pc;
   logic [XLEN-1:0]             in_imm;
   logic [XLEN-1:0]             in_rs1;
   logic [XLEN-1:0]             in_rs2;
   logic                        in_pred_taken;

   // registered result towards writeback/commit
   logic                        out_valid;
   logic                        out_ready;
   logic                        out_taken;
   logic [XLEN-1:0]             out_next_pc;
   logic                        out_mispredict;
   logic                        out_exc_illegal;
   logic                        out_exc_misaligned;

   // one-cycle redirect towards fetch
   logic                        redirect_valid;
   logic [XLEN-1:0]             redirect_pc;

   // environment side: drives the request and the downstream ready
   modport master (
      output in_valid, in_kind, in_pc, in_imm, in_rs1, in_rs2, in_pred_taken,
      output out_ready,
      input  in_ready,
      input  out_valid, out_taken, out_next_pc, out_mispredict,
      input  out_exc_illegal, out_exc_misaligned,
      input  redirect_valid, redirect_pc
   );

   // stage side: the exec_branch block itself
   modport slave (
      input  in_valid, in_kind, in_pc, in_imm, in_rs1, in_rs2, in_pred_taken,
      input  out_ready,
      output in_ready,
      output out_valid, out_taken, out_next_pc, out_mispredict,
      output out_exc_illegal, out_exc_misaligned,
      output redirect_valid, redirect_pc
   );
endinterface

// File: rtl/exec_branch.sv
// Branch execute stage: resolves direction/target, flags mispredicts and exceptions.
// Latency: one cycle from capture to out_valid; redirect pulses with the first valid cycle.
// Backpressure: single output register; in_ready drops while full without out_ready or after a mispredict until flush.

module exec_branch
   import exec_branch_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   exec_branch_if.slave     bus,
   output logic [CNT_W-1:0] cnt_branches,
   output logic [CNT_W-1:0] cnt_mispredicts
);

   localparam logic [1:0] ST_EMPTY      = 2'd0;
   localparam logic [1:0] ST_FULL       = 2'd1;
   localparam logic [1:0] ST_WAIT_FULL  = 2'd2;
   localparam logic [1:0] ST_WAIT_EMPTY = 2'd3;

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic [1:0]       state_q, state_d;
   logic             taken_q, taken_d;
   logic [XLEN-1:0]  next_pc_q, next_pc_d;
   logic             mispredict_q, mispredict_d;
   logic             exc_illegal_q, exc_illegal_d;
   logic             exc_misaligned_q, exc_misaligned_d;
   logic             redirect_q, redirect_d;
   logic [CNT_W-1:0] cnt_branches_q, cnt_branches_d;
   logic [CNT_W-1:0] cnt_mispredicts_q, cnt_mispredicts_d;

   logic             res_taken;
   logic             res_illegal;
   logic             res_misaligned;
   logic             res_mispredict;
   logic [XLEN-1:0]  res_target;
   logic [XLEN-1:0]  res_fallthrough;
   logic [XLEN-1:0]  res_next_pc;
   logic             ops_eq;
   logic             ops_lt_s;
   logic             ops_lt_u;
   logic             in_ready_w;
   logic             capture;

   // Resolve direction, target and exception flags for the request on the input side.
   always_comb begin
      ops_eq          = (bus.in_rs1 == bus.in_rs2);
      ops_lt_s        = ($signed(bus.in_rs1) < $signed(bus.in_rs2));
      ops_lt_u        = (bus.in_rs1 < bus.in_rs2);
      res_target      = bus.in_pc + bus.in_imm;
      res_fallthrough = bus.in_pc + PC_STEP;
      res_taken       = 1'b0;
      res_illegal     = 1'b0;
      case (bus.in_kind)
         bk_beq:  res_taken = ops_eq;
         bk_bne:  res_taken = !ops_eq;
         bk_blt:  res_taken = ops_lt_s;
         bk_bge:  res_taken = !ops_lt_s;
         bk_bltu: res_taken = ops_lt_u;
         bk_bgeu: res_taken = !ops_lt_u;
         default: res_illegal = 1'b1;
      endcase
      res_next_pc    = res_taken ? res_target : res_fallthrough;
      res_misaligned = res_taken && (res_target[1:0] != 2'b00);
      // an excepting branch never redirects; commit handles it as a trap instead
      res_mispredict = !res_illegal && !res_misaligned && (res_taken != bus.in_pred_taken);
   end

   // Accept handshake: free when empty, or when the held result leaves this cycle.
   always_comb begin
      in_ready_w = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && bus.out_ready);
      capture    = bus.in_valid && in_ready_w && !flush;
   end

   // Occupancy / post-mispredict sequencing.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (capture) begin
               state_d = res_mispredict ? ST_WAIT_FULL : ST_FULL;
            end
         end
         ST_FULL: begin
            if (flush) begin
               state_d = ST_EMPTY;
            end else if (bus.out_ready) begin
               if (capture) begin
                  state_d = res_mispredict ? ST_WAIT_FULL : ST_FULL;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
         end
         ST_WAIT_FULL: begin
            // the mispredicted branch itself is still good; flush only unblocks intake
            if (flush && bus.out_ready) begin
               state_d = ST_EMPTY;
            end else if (flush) begin
               state_d = ST_FULL;
            end else if (bus.out_ready) begin
               state_d = ST_WAIT_EMPTY;
            end
         end
         ST_WAIT_EMPTY: begin
            if (flush) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Result register loads on capture only, so fields hold steady under backpressure.
   always_comb begin
      taken_d          = taken_q;
      next_pc_d        = next_pc_q;
      mispredict_d     = mispredict_q;
      exc_illegal_d    = exc_illegal_q;
      exc_misaligned_d = exc_misaligned_q;
      redirect_d       = capture && res_mispredict;
      if (capture) begin
         taken_d          = res_taken;
         next_pc_d        = res_next_pc;
         mispredict_d     = res_mispredict;
         exc_illegal_d    = res_illegal;
         exc_misaligned_d = res_misaligned;
      end
   end

   // Saturating statistics, advanced by captured branches.
   always_comb begin
      cnt_branches_d    = cnt_branches_q;
      cnt_mispredicts_d = cnt_mispredicts_q;
      if (capture && !res_illegal && (cnt_branches_q != {CNT_W{1'b1}})) begin
         cnt_branches_d = cnt_branches_q + CNT_W'(1);
      end
      if (capture && res_mispredict && (cnt_mispredicts_q != {CNT_W{1'b1}})) begin
         cnt_mispredicts_d = cnt_mispredicts_q + CNT_W'(1);
      end
   end

   // State and result flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= ST_EMPTY;
         taken_q           <= 1'b0;
         next_pc_q         <= '0;
         mispredict_q      <= 1'b0;
         exc_illegal_q     <= 1'b0;
         exc_misaligned_q  <= 1'b0;
         redirect_q        <= 1'b0;
         cnt_branches_q    <= '0;
         cnt_mispredicts_q <= '0;
      end else begin
         state_q           <= state_d;
         taken_q           <= taken_d;
         next_pc_q         <= next_pc_d;
         mispredict_q      <= mispredict_d;
         exc_illegal_q     <= exc_illegal_d;
         exc_misaligned_q  <= exc_misaligned_d;
         redirect_q        <= redirect_d;
         cnt_branches_q    <= cnt_branches_d;
         cnt_mispredicts_q <= cnt_mispredicts_d;
      end
   end

   assign bus.in_ready           = in_ready_w;
   assign bus.out_valid          = (state_q == ST_FULL) || (state_q == ST_WAIT_FULL);
   assign bus.out_taken          = taken_q;
   assign bus.out_next_pc        = next_pc_q;
   assign bus.out_mispredict     = mispredict_q;
   assign bus.out_exc_illegal    = exc_illegal_q;
   assign bus.out_exc_misaligned = exc_misaligned_q;
   assign bus.redirect_valid     = redirect_q;
   assign bus.redirect_pc        = next_pc_q;
   assign cnt_branches           = cnt_branches_q;
   assign cnt_mispredicts        = cnt_mispredicts_q;

endmodule
